// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard for the ID stage.
// Keeps one small counter of in-flight writes per architectural register.
// Raises a combinational stall when the presented instruction reads a busy
// register or would push its destination counter past the maximum.
module dest_reg_scoreboard #(
  parameter int REG_BITS  = 5,
  parameter int NREGS     = 32,
  parameter int CNT_BITS  = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_we,
  input  logic [REG_BITS-1:0] issue_dst,
  input  logic [REG_BITS-1:0] src1,
  input  logic [REG_BITS-1:0] src2,
  input  logic                wb_valid,
  input  logic [REG_BITS-1:0] wb_dst,
  output logic                src1_busy,
  output logic                src2_busy,
  output logic                stall,
  output logic [NREGS-1:0]    busy_vec,
  output logic                ovf_err,
  output logic                unf_err
);

  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic                BYPASS_EN = (WB_BYPASS != 0);

  // Current count per register; entry 0 is tied to zero.
  logic [CNT_BITS-1:0] cnt_arr [NREGS];

  // Per-register error events for this cycle, reduced into the sticky flags.
  logic [NREGS-1:0] ovf_hit;
  logic [NREGS-1:0] unf_hit;

  logic dst_full;
  logic fire_cand;
  logic src1_hit;
  logic src2_hit;
  logic issue_fire;

  // Hazard evaluation. The bypass exclusion uses the issue candidate without
  // its source-busy terms; using the final issue_fire there would form a
  // combinational loop with no stable solution when an instruction reads and
  // writes the same retiring register. That case stalls for one cycle.
  always_comb begin
    dst_full  = issue_we && (issue_dst != '0) && (cnt_arr[issue_dst] == CNT_MAX);
    fire_cand = issue_valid && issue_we && (issue_dst != '0) && !dst_full;

    src1_hit = BYPASS_EN && wb_valid && (wb_dst == src1) &&
               (cnt_arr[src1] == CNT_ONE) && !(fire_cand && (issue_dst == src1));
    src2_hit = BYPASS_EN && wb_valid && (wb_dst == src2) &&
               (cnt_arr[src2] == CNT_ONE) && !(fire_cand && (issue_dst == src2));

    src1_busy = !rst && (src1 != '0) && (cnt_arr[src1] != CNT_ZERO) && !src1_hit;
    src2_busy = !rst && (src2 != '0) && (cnt_arr[src2] != CNT_ZERO) && !src2_hit;

    stall      = !rst && issue_valid && (src1_busy || src2_busy || dst_full);
    issue_fire = issue_valid && issue_we && (issue_dst != '0) && !stall;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // Register 0 is hardwired and never tracked.
        assign cnt_arr[gi] = CNT_ZERO;
        assign ovf_hit[gi] = 1'b0;
        assign unf_hit[gi] = 1'b0;
      end else begin : g_cnt
        logic                inc;
        logic                dec;
        logic [CNT_BITS-1:0] cnt_reg;

        assign inc = issue_fire && (issue_dst == REG_BITS'(gi));
        assign dec = wb_valid && (wb_dst == REG_BITS'(gi));

        // Saturating up/down counter; simultaneous inc and dec cancel.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            cnt_reg <= CNT_ZERO;
          end else begin
            case ({inc, dec})
              2'b10:   if (cnt_reg != CNT_MAX)  cnt_reg <= cnt_reg + CNT_ONE;
              2'b01:   if (cnt_reg != CNT_ZERO) cnt_reg <= cnt_reg - CNT_ONE;
              default: cnt_reg <= cnt_reg;
            endcase
          end
        end

        assign cnt_arr[gi] = cnt_reg;
        assign ovf_hit[gi] = inc && !dec && (cnt_reg == CNT_MAX);
        assign unf_hit[gi] = dec && !inc && (cnt_reg == CNT_ZERO);
      end

      assign busy_vec[gi] = (cnt_arr[gi] != CNT_ZERO);
    end
  endgenerate

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (|ovf_hit) ovf_err <= 1'b1;
      if (|unf_hit) unf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Table-driven bench for dest_reg_scoreboard. Combinational hazard outputs
// are checked mid-cycle; post-edge state is pushed into a scoreboard queue
// when a vector is driven and popped for comparison after the clock edge.
module tb_dest_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_dst;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic        src1_busy;
  logic        src2_busy;
  logic        stall;
  logic [31:0] busy_vec;
  logic        ovf_err;
  logic        unf_err;

  // Second instance without writeback bypass, sharing all inputs.
  logic        nb_src1_busy;
  logic        nb_src2_busy;
  logic        nb_stall;
  logic [31:0] nb_busy_vec;
  logic        nb_ovf_err;
  logic        nb_unf_err;

  int n_checks = 0;
  int n_fail   = 0;

  dest_reg_scoreboard #(.REG_BITS(5), .NREGS(32), .CNT_BITS(2), .WB_BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst),
    .src1(src1), .src2(src2),
    .wb_valid(wb_valid), .wb_dst(wb_dst),
    .src1_busy(src1_busy), .src2_busy(src2_busy), .stall(stall),
    .busy_vec(busy_vec), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  dest_reg_scoreboard #(.REG_BITS(5), .NREGS(32), .CNT_BITS(2), .WB_BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst),
    .src1(src1), .src2(src2),
    .wb_valid(wb_valid), .wb_dst(wb_dst),
    .src1_busy(nb_src1_busy), .src2_busy(nb_src2_busy), .stall(nb_stall),
    .busy_vec(nb_busy_vec), .ovf_err(nb_ovf_err), .unf_err(nb_unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        iwe;
    logic [4:0]  idst;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        wv;
    logic [4:0]  wd;
    logic        e_s1b;
    logic        e_s2b;
    logic        e_stall;
    logic        e_stall_nb;
    logic [31:0] e_busy;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  typedef struct {
    logic [31:0] busy;
    logic        ovf;
    logic        unf;
  } post_t;

  localparam int NVEC = 17;
  vec_t  vecs [NVEC];
  post_t sb_q [$];

  function automatic vec_t mk(
    input logic iv, input logic iwe, input logic [4:0] idst,
    input logic [4:0] s1, input logic [4:0] s2,
    input logic wv, input logic [4:0] wd,
    input logic e_s1b, input logic e_s2b, input logic e_stall, input logic e_stall_nb,
    input logic [31:0] e_busy, input logic e_ovf, input logic e_unf);
    vec_t v;
    v.iv = iv; v.iwe = iwe; v.idst = idst; v.s1 = s1; v.s2 = s2;
    v.wv = wv; v.wd = wd;
    v.e_s1b = e_s1b; v.e_s2b = e_s2b; v.e_stall = e_stall; v.e_stall_nb = e_stall_nb;
    v.e_busy = e_busy; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_we = v.iwe; issue_dst = v.idst;
    src1 = v.s1; src2 = v.s2; wb_valid = v.wv; wb_dst = v.wd;
  endtask

  initial begin
    post_t p;
    post_t got;
    vec_t  idle;

    //            iv iwe dst s1  s2  wv wd   s1b s2b stl nb  busy          ovf unf
    vecs[0]  = mk(1, 1,  5,  0,  0,  0, 0,   0,  0,  0,  0,  32'h0000_0020, 0, 0);
    vecs[1]  = mk(1, 0,  0,  5,  0,  0, 0,   1,  0,  1,  1,  32'h0000_0020, 0, 0);
    vecs[2]  = mk(1, 0,  0,  0,  5,  1, 5,   0,  0,  0,  1,  32'h0000_0000, 0, 0);
    vecs[3]  = mk(1, 1,  7,  0,  0,  0, 0,   0,  0,  0,  0,  32'h0000_0080, 0, 0);
    vecs[4]  = mk(1, 1,  7,  0,  0,  0, 0,   0,  0,  0,  0,  32'h0000_0080, 0, 0);
    vecs[5]  = mk(1, 1,  7,  0,  0,  0, 0,   0,  0,  0,  0,  32'h0000_0080, 0, 0);
    vecs[6]  = mk(1, 1,  7,  0,  0,  0, 0,   0,  0,  1,  1,  32'h0000_0080, 0, 0);
    vecs[7]  = mk(0, 0,  0,  7,  0,  1, 7,   1,  0,  0,  0,  32'h0000_0080, 0, 0);
    vecs[8]  = mk(0, 0,  0,  7,  0,  1, 7,   1,  0,  0,  0,  32'h0000_0080, 0, 0);
    vecs[9]  = mk(0, 0,  0,  0,  0,  1, 7,   0,  0,  0,  0,  32'h0000_0000, 0, 0);
    vecs[10] = mk(1, 1,  0,  0,  0,  1, 0,   0,  0,  0,  0,  32'h0000_0000, 0, 0);
    vecs[11] = mk(0, 0,  0,  0,  0,  1, 9,   0,  0,  0,  0,  32'h0000_0000, 0, 1);
    vecs[12] = mk(1, 1,  9,  0,  0,  1, 9,   0,  0,  0,  0,  32'h0000_0000, 0, 1);
    vecs[13] = mk(0, 0,  0,  0,  0,  0, 0,   0,  0,  0,  0,  32'h0000_0000, 0, 1);
    vecs[14] = mk(1, 1,  3,  0,  0,  0, 0,   0,  0,  0,  0,  32'h0000_0008, 0, 1);
    vecs[15] = mk(1, 1,  12, 0,  0,  0, 0,   0,  0,  0,  0,  32'h0000_1008, 0, 1);
    vecs[16] = mk(0, 0,  0,  3,  12, 0, 0,   1,  1,  0,  0,  32'h0000_1008, 0, 1);

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);

    // Reset state
    rst = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy_vec", busy_vec, 32'h0);
    chk("reset stall", {31'b0, stall}, 32'h0);
    chk("reset ovf_err", {31'b0, ovf_err}, 32'h0);
    chk("reset unf_err", {31'b0, unf_err}, 32'h0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      #2;
      chk($sformatf("v%0d src1_busy", i), {31'b0, src1_busy}, {31'b0, vecs[i].e_s1b});
      chk($sformatf("v%0d src2_busy", i), {31'b0, src2_busy}, {31'b0, vecs[i].e_s2b});
      chk($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
      chk($sformatf("v%0d stall_nobypass", i), {31'b0, nb_stall}, {31'b0, vecs[i].e_stall_nb});
      p.busy = vecs[i].e_busy; p.ovf = vecs[i].e_ovf; p.unf = vecs[i].e_unf;
      sb_q.push_back(p);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL v%0d scoreboard: got empty queue expected entry", i);
      end else begin
        got = sb_q.pop_front();
        chk($sformatf("v%0d busy_vec", i), busy_vec, got.busy);
        chk($sformatf("v%0d ovf_err", i), {31'b0, ovf_err}, {31'b0, got.ovf});
        chk($sformatf("v%0d unf_err", i), {31'b0, unf_err}, {31'b0, got.unf});
      end
      $display("vec %0d: iv=%0b we=%0b dst=%0d s1=%0d s2=%0d wb=%0b/%0d -> stall=%0b busy_vec=%h ovf=%0b unf=%0b",
               i, vecs[i].iv, vecs[i].iwe, vecs[i].idst, vecs[i].s1, vecs[i].s2,
               vecs[i].wv, vecs[i].wd, stall, busy_vec, ovf_err, unf_err);
    end

    // Asynchronous reset between edges with counts on registers 3 and 12
    issue_valid = 1'b1; issue_we = 1'b0; issue_dst = 5'd0;
    src1 = 5'd3; src2 = 5'd0; wb_valid = 1'b0; wb_dst = 5'd0;
    #1;
    chk("pre-reset stall", {31'b0, stall}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async reset busy_vec", busy_vec, 32'h0);
    chk("async reset stall", {31'b0, stall}, 32'h0);
    chk("async reset src1_busy", {31'b0, src1_busy}, 32'h0);
    chk("async reset ovf_err", {31'b0, ovf_err}, 32'h0);
    chk("async reset unf_err", {31'b0, unf_err}, 32'h0);
    $display("async reset: stall=%0b busy_vec=%h unf=%0b", stall, busy_vec, unf_err);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(idle);
    @(posedge clk);
    #1;
    chk("post-reset busy_vec", busy_vec, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
